// File: rtl/keypad_pkg.sv
// Shared keypad-scanner definitions: FSM state encoding, default matrix geometry,
// column reset strobe and the row/column to key-code mapping.
package keypad_pkg;

    localparam int NUM_ROWS_DEF = 4;
    localparam int NUM_COLS_DEF = 4;
    localparam int CW           = $clog2(NUM_ROWS_DEF * NUM_COLS_DEF);

    typedef logic [1:0] state_t;

    localparam state_t SCAN     = 2'd0;
    localparam state_t DEBOUNCE = 2'd1;
    localparam state_t HELD     = 2'd2;
    localparam state_t RELEASE  = 2'd3;

    // Active-low one-hot strobe with column 0 driven.
    localparam logic [NUM_COLS_DEF-1:0] COL_RESET = {{(NUM_COLS_DEF-1){1'b1}}, 1'b0};

    function automatic int key_code(input int row, input int col, input int ncols);
        return row * ncols + col;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the raw, asynchronous active-low keypad row lines.
// Latency: 2 Clock cycles. No backpressure; samples every cycle.
// Flops reset to all-ones so a reset never looks like a pressed key.
module keypad_row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] rows_raw,
    output logic [WIDTH-1:0] rows_sync
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            meta_q    <= '1;
            rows_sync <= '1;
        end else begin
            meta_q    <= rows_raw;
            rows_sync <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scan_fsm.sv
// Keypad matrix scanner: column strobing, tick-based press/release debounce, one code per press.
// Latency: KeyValid rises on the edge that samples the confirming ScanTick; rows see a 2-cycle sync delay.
// Backpressure: single-entry output held until KeyAck; confirms arriving while full set sticky Overrun.
// Build option: define KEYPAD_AUTOREPEAT_EN for auto-repeat of a held key.
module keypad_scan_fsm
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS       = NUM_ROWS_DEF,
    parameter int NUM_COLS       = NUM_COLS_DEF,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 20,
    parameter int REPEAT_RATE    = 5
) (
    input  logic                                  Clock,
    input  logic                                  Reset,
    input  logic                                  ScanTick,
    input  logic [NUM_ROWS-1:0]                   Rows,
    output logic [NUM_COLS-1:0]                   Cols,
    output logic                                  KeyValid,
    output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]  KeyCode,
    input  logic                                  KeyAck,
    output logic                                  Overrun
);

    localparam int KCW  = $clog2(NUM_ROWS * NUM_COLS);
    localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CLW  = $clog2(NUM_COLS);
    localparam int CNTW = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [NUM_COLS-1:0] COL_INIT = {{(NUM_COLS-1){1'b1}}, 1'b0};

    if (NUM_ROWS < 1 || NUM_COLS < 2 || DEBOUNCE_TICKS < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("keypad_scan_fsm: illegal parameter combination");
    end

    logic [NUM_ROWS-1:0] rows_s;
    logic [NUM_ROWS-1:0] low;
    logic                none_low;
    logic                one_low;
    logic [RW-1:0]       low_idx;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RW-1:0]   row_q, row_d;
    logic [CLW-1:0]  col_idx;
    logic            advance;
    logic            confirm_press;
    logic            confirm;
    logic            same_row;
    logic [KCW-1:0]  code_d;

    keypad_row_sync #(
        .WIDTH     (NUM_ROWS)
    ) u_row_sync (
        .Clock     (Clock),
        .Reset     (Reset),
        .rows_raw  (Rows),
        .rows_sync (rows_s)
    );

    assign low      = ~rows_s;
    assign none_low = (low == '0);
    assign one_low  = !none_low && ((low & (low - NUM_ROWS'(1))) == '0);

    always_comb begin
        low_idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (low[i]) begin
                low_idx = RW'(i);
            end
        end
    end

    assign same_row = one_low && (low_idx == row_q);
    assign cnt_inc  = cnt_q + CNTW'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_d         = row_q;
        advance       = 1'b0;
        confirm_press = 1'b0;
        if (ScanTick) begin
            case (state_q)
                SCAN: begin
                    if (one_low) begin
                        row_d = low_idx;
                        cnt_d = CNTW'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            confirm_press = 1'b1;
                            state_d       = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (same_row) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNTW'(DEBOUNCE_TICKS)) begin
                            confirm_press = 1'b1;
                            state_d       = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                        advance = 1'b1;
                    end
                end
                HELD: begin
                    if (none_low) begin
                        cnt_d = CNTW'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d = SCAN;
                            advance = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (none_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNTW'(DEBOUNCE_TICKS)) begin
                            state_d = SCAN;
                            advance = 1'b1;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPTW    = $clog2(RPT_MAX + 1);

    logic [RPTW-1:0] rpt_cnt;
    logic [RPTW-1:0] rpt_inc;
    logic [RPTW-1:0] rpt_limit;
    logic            rpt_phase;
    logic            stay_held;
    logic            repeat_fire;

    assign stay_held   = (state_q == HELD) && (state_d == HELD);
    assign rpt_inc     = rpt_cnt + RPTW'(1);
    // First repeat waits the long delay, later ones use the shorter rate.
    assign rpt_limit   = rpt_phase ? RPTW'(REPEAT_RATE) : RPTW'(REPEAT_DELAY);
    assign repeat_fire = ScanTick && stay_held && (rpt_inc == rpt_limit);

    always_ff @(posedge Clock) begin
        if (Reset || !stay_held) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else if (ScanTick) begin
            if (repeat_fire) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b1;
            end else begin
                rpt_cnt <= rpt_inc;
            end
        end
    end

    assign confirm = confirm_press || repeat_fire;
`else
    assign confirm = confirm_press;
`endif

    assign code_d = KCW'(key_code(int'(row_d), int'(col_idx), NUM_COLS));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            row_q   <= '0;
            col_idx <= '0;
            Cols    <= COL_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            if (advance) begin
                col_idx <= (col_idx == CLW'(NUM_COLS - 1)) ? '0 : col_idx + CLW'(1);
                Cols    <= {Cols[NUM_COLS-2:0], Cols[NUM_COLS-1]};
            end
        end
    end

    // An ack in the same cycle as a confirm frees the slot, so the new code is taken without overrun.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            KeyValid <= 1'b0;
            KeyCode  <= '0;
            Overrun  <= 1'b0;
        end else begin
            if (KeyValid && KeyAck) begin
                KeyValid <= 1'b0;
                Overrun  <= 1'b0;
            end
            if (confirm) begin
                if (!KeyValid || KeyAck) begin
                    KeyValid <= 1'b1;
                    KeyCode  <= code_d;
                end else begin
                    Overrun <= 1'b1;
                end
            end
        end
    end

endmodule
